// File: rtl/wb_board_master.sv
// wb_board_master: autonomous wishbone initiator for the board IO responder.
// On a trigger it reads the switches and buttons, mirrors the switches onto the
// LEDs and shows the button bitmap on the 7-seg text register.
// Optional feature macro: BOARD_MASTER_POLL_EN (periodic self-trigger).
module wb_board_master #(
  parameter int DEV_ADDR_BITS = 8,
  parameter int TIMEOUT       = 255,
  parameter int POLL_INTERVAL = 100000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  output logic                     wbm_cyc_o,
  output logic                     wbm_stb_o,
  output logic [DEV_ADDR_BITS-3:0] wbm_addr_o,
  output logic [3:0]               wbm_sel_o,
  output logic                     wbm_we_o,
  output logic [31:0]              wbm_data_o,
  input  logic [31:0]              wbm_data_i,
  input  logic                     wbm_ack_i,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [15:0]              sw_snap,
  output logic [19:0]              btn_snap
);

  localparam int AW = DEV_ADDR_BITS - 2;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD_SW  = 3'd1,
    S_RD_BTN = 3'd2,
    S_WR_LED = 3'd3,
    S_WR_TXT = 3'd4,
    S_GAP    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  state_t        state_r;
  state_t        next_r;
  logic          pending_r;
  logic [TW-1:0] tcnt_r;
  logic          start_req_s;

  // Upper read-data bits carry nothing the sequence needs.
  logic data_unused;
  assign data_unused = ^wbm_data_i[31:20];

`ifdef BOARD_MASTER_POLL_EN
  localparam int PW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  logic [PW-1:0] poll_cnt_r;
  logic          poll_wrap_s;

  assign poll_wrap_s = (poll_cnt_r == PW'(POLL_INTERVAL - 1));
  assign start_req_s = trigger | poll_wrap_s;

  // Free-running poll counter; wraps regardless of busy so a wrap can set pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      poll_cnt_r <= '0;
    end else if (poll_wrap_s) begin
      poll_cnt_r <= '0;
    end else begin
      poll_cnt_r <= poll_cnt_r + PW'(1);
    end
  end
`else
  assign start_req_s = trigger;
`endif

  // Sequencer: one FSM owning the bus, status flags and the snapshots.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      next_r     <= S_IDLE;
      pending_r  <= 1'b0;
      tcnt_r     <= '0;
      wbm_cyc_o  <= 1'b0;
      wbm_stb_o  <= 1'b0;
      wbm_addr_o <= '0;
      wbm_sel_o  <= 4'h0;
      wbm_we_o   <= 1'b0;
      wbm_data_o <= 32'h0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      sw_snap    <= 16'h0;
      btn_snap   <= 20'h0;
    end else begin
      done <= 1'b0;
      // Requests arriving mid-sequence merge into a single pending restart.
      if (start_req_s && (state_r != S_IDLE)) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        S_IDLE: begin
          if (start_req_s) begin
            state_r <= S_RD_SW;
            busy    <= 1'b1;
            err     <= 1'b0;
          end
        end
        S_RD_SW, S_RD_BTN, S_WR_LED, S_WR_TXT: begin
          if (!wbm_cyc_o) begin
            // Issue phase: present the transaction one cycle after entering the state.
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            tcnt_r    <= '0;
            case (state_r)
              S_RD_SW: begin
                wbm_addr_o <= AW'(0);
                wbm_we_o   <= 1'b0;
                wbm_sel_o  <= 4'hF;
                wbm_data_o <= 32'h0;
              end
              S_RD_BTN: begin
                wbm_addr_o <= AW'(1);
                wbm_we_o   <= 1'b0;
                wbm_sel_o  <= 4'hF;
                wbm_data_o <= 32'h0;
              end
              S_WR_LED: begin
                wbm_addr_o <= AW'(4);
                wbm_we_o   <= 1'b1;
                wbm_sel_o  <= 4'h3;
                wbm_data_o <= {16'h0, sw_snap};
              end
              default: begin
                wbm_addr_o <= AW'(6);
                wbm_we_o   <= 1'b1;
                wbm_sel_o  <= 4'hF;
                wbm_data_o <= {12'h0, btn_snap};
              end
            endcase
          end else if (wbm_ack_i) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_addr_o <= '0;
            wbm_sel_o  <= 4'h0;
            wbm_we_o   <= 1'b0;
            wbm_data_o <= 32'h0;
            case (state_r)
              S_RD_SW: begin
                sw_snap <= wbm_data_i[15:0];
                next_r  <= S_RD_BTN;
                state_r <= S_GAP;
              end
              S_RD_BTN: begin
                btn_snap <= wbm_data_i[19:0];
                next_r   <= S_WR_LED;
                state_r  <= S_GAP;
              end
              S_WR_LED: begin
                next_r  <= S_WR_TXT;
                state_r <= S_GAP;
              end
              default: begin
                state_r <= S_DONE;
                done    <= 1'b1;
              end
            endcase
          end else if (tcnt_r == TW'(TIMEOUT - 1)) begin
            wbm_cyc_o  <= 1'b0;
            wbm_stb_o  <= 1'b0;
            wbm_addr_o <= '0;
            wbm_sel_o  <= 4'h0;
            wbm_we_o   <= 1'b0;
            wbm_data_o <= 32'h0;
            err        <= 1'b1;
            state_r    <= S_ERR;
          end else begin
            tcnt_r <= tcnt_r + TW'(1);
          end
        end
        S_GAP: begin
          state_r <= next_r;
        end
        S_DONE, S_ERR: begin
          // A request seen during or before this cycle restarts without going idle.
          if (pending_r || start_req_s) begin
            pending_r <= 1'b0;
            err       <= 1'b0;
            state_r   <= S_RD_SW;
          end else begin
            busy    <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          busy       <= 1'b0;
          wbm_cyc_o  <= 1'b0;
          wbm_stb_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_board_master.sv
// Self-checking bench for wb_board_master: randomized switch/button values and
// responder wait states, checked against a transaction-level reference model.
module tb_wb_board_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger;
  logic        cyc, stb, we, ack, busy, done, err;
  logic [5:0]  addr;
  logic [3:0]  sel;
  logic [31:0] data_o, data_i;
  logic [15:0] sw_snap;
  logic [19:0] btn_snap;

  int n_tests = 0;
  int n_fail  = 0;

  // responder configuration
  logic [15:0] sw_val  = 16'h0;
  logic [19:0] btn_val = 20'h0;
  int          waits   = 0;
  logic        noack_btn = 1'b0;
  int          wcnt = 0;
  logic [31:0] rnd  = 32'h0;

  // monitors
  typedef struct packed {
    logic [5:0]  a;
    logic        w;
    logic [3:0]  s;
    logic [31:0] d;
  } txn_t;
  txn_t log_q[$];
  txn_t exp_q[$];
  int   runs[$];
  int   cur_run  = 0;
  int   done_cnt = 0;
  int   bus_bad  = 0;
  int   busy_rise = 0;
  logic busy_d = 1'b0;

  always #5 clk = ~clk;

  wb_board_master #(.DEV_ADDR_BITS(8), .TIMEOUT(TO), .POLL_INTERVAL(50)) dut (
    .clk(clk), .rst(rst), .trigger(trigger),
    .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_addr_o(addr), .wbm_sel_o(sel),
    .wbm_we_o(we), .wbm_data_o(data_o), .wbm_data_i(data_i), .wbm_ack_i(ack),
    .busy(busy), .done(done), .err(err), .sw_snap(sw_snap), .btn_snap(btn_snap)
  );

  // Responder: acks after 'waits' stall cycles; optionally never acks the button read.
  assign ack = cyc && stb && (wcnt == waits) && !(noack_btn && addr == 6'd1);
  assign data_i = (addr == 6'd0) ? {rnd[31:16], sw_val} :
                  (addr == 6'd1) ? {rnd[31:20], btn_val} : rnd;

  always @(posedge clk) begin
    rnd  <= $urandom;
    wcnt <= (cyc && stb && !ack) ? wcnt + 1 : 0;
  end

  always @(negedge clk) begin
    if (cyc && ack) log_q.push_back('{addr, we, sel, data_o});
    if (cyc) cur_run++;
    else if (cur_run != 0) begin runs.push_back(cur_run); cur_run = 0; end
    if (done) done_cnt++;
    if (stb !== cyc) bus_bad++;
    if (!cyc && (we !== 1'b0 || sel !== 4'h0 || addr !== 6'h0 || data_o !== 32'h0)) bus_bad++;
    if (busy && !busy_d) busy_rise++;
    busy_d = busy;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: what one successful sequence must put on the bus.
  function automatic void build_exp(input logic [15:0] sw, input logic [19:0] btn);
    exp_q.delete();
    exp_q.push_back('{6'd0, 1'b0, 4'hF, 32'h0});
    exp_q.push_back('{6'd1, 1'b0, 4'hF, 32'h0});
    exp_q.push_back('{6'd4, 1'b1, 4'h3, {16'h0, sw}});
    exp_q.push_back('{6'd6, 1'b1, 4'hF, {12'h0, btn}});
  endfunction

  task automatic pulse_trigger();
    @(negedge clk) trigger = 1'b1;
    @(negedge clk) trigger = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    check_eq({tag, "_finish"}, (n < 500), 1);
  endtask

  task automatic run_seq(input logic [15:0] sw, input logic [19:0] btn, input int w, input string tag);
    int d0;
    sw_val = sw; btn_val = btn; waits = w;
    log_q.delete(); runs.delete(); d0 = done_cnt;
    build_exp(sw, btn);
    pulse_trigger();
    check_eq({tag, "_busy"}, busy, 1);
    wait_idle(tag);
    check_eq({tag, "_ntxn"}, log_q.size(), 4);
    for (int i = 0; i < log_q.size() && i < 4; i++)
      check_eq($sformatf("%s_txn%0d", tag, i), log_q[i], exp_q[i]);
    check_eq({tag, "_nruns"}, runs.size(), 4);
    for (int i = 0; i < runs.size(); i++)
      check_eq($sformatf("%s_stb_len%0d", tag, i), runs[i], w + 1);
    check_eq({tag, "_done"}, done_cnt - d0, 1);
    check_eq({tag, "_sw_snap"}, sw_snap, sw);
    check_eq({tag, "_btn_snap"}, btn_snap, btn);
    check_eq({tag, "_err"}, err, 0);
  endtask

  initial begin
    logic [15:0] sw;
    logic [19:0] btn;
    int d0;
    rst = 1'b1; trigger = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_cyc", {cyc, stb, we, sel}, 0);
    check_eq("rst_addr_data", {addr, data_o}, 0);
    check_eq("rst_status", {busy, done, err}, 0);
    check_eq("rst_snaps", {sw_snap, btn_snap}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_seq(16'hA5C3, 20'h0_0012, 0, "basic");
    run_seq($urandom, $urandom, 3, "wait3");
    for (int k = 0; k < 6; k++)
      run_seq($urandom, $urandom, $urandom_range(0, 3), $sformatf("rnd%0d", k));

    // Timeout on the button read.
    sw = $urandom; btn = btn_snap;
    sw_val = sw; btn_val = $urandom; waits = 0; noack_btn = 1'b1;
    log_q.delete(); runs.delete(); d0 = done_cnt;
    pulse_trigger();
    wait_idle("tmo");
    check_eq("tmo_err", err, 1);
    check_eq("tmo_no_done", done_cnt - d0, 0);
    check_eq("tmo_ntxn", log_q.size(), 1);
    check_eq("tmo_nruns", runs.size(), 2);
    if (runs.size() == 2) check_eq("tmo_stb_len", runs[1], TO);
    check_eq("tmo_sw_snap", sw_snap, sw);
    check_eq("tmo_btn_keep", btn_snap, btn);
    noack_btn = 1'b0;
    d0 = done_cnt;
    pulse_trigger();
    check_eq("tmo_err_clr", err, 0);
    wait_idle("tmo_rec");
    check_eq("tmo_rec_done", done_cnt - d0, 1);

    // Triggers while busy merge into one extra sequence.
    sw_val = $urandom; btn_val = $urandom; waits = $urandom_range(0, 2);
    log_q.delete(); d0 = done_cnt;
    pulse_trigger();
    for (int k = 0; k < 3; k++) begin
      repeat (2) @(negedge clk);
      pulse_trigger();
    end
    wait_idle("pend");
    check_eq("pend_done", done_cnt - d0, 2);
    check_eq("pend_ntxn", log_q.size(), 8);

    // Asynchronous reset in the middle of the LED write.
    sw_val = $urandom; btn_val = $urandom; waits = 2;
    begin
      int n = 0;
      pulse_trigger();
      while (!(cyc && addr == 6'd4) && n < 100) begin @(negedge clk); n++; end
      check_eq("arst_reach_led", (n < 100), 1);
    end
    #2 rst = 1'b1;
    #1;
    check_eq("arst_bus", {cyc, stb}, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_snaps", {sw_snap, btn_snap}, 0);
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("arst_idle", {busy, cyc}, 0);
    runs.delete(); cur_run = 0;
    run_seq($urandom, $urandom, 1, "post_rst");

    // Self-trigger behaviour with the trigger port held low.
    d0 = busy_rise;
    repeat (160) @(negedge clk);
`ifdef BOARD_MASTER_POLL_EN
    check_eq("poll_starts", (busy_rise - d0 >= 2), 1);
`else
    check_eq("no_poll_starts", busy_rise - d0, 0);
`endif

    check_eq("bus_protocol", bus_bad, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
